decoder_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one decoder-selected resource among WIDTH requesters.
- Drives the `sel`/`enable` pair of a downstream `Decoder`, so exactly one decoder output, the grant, is active at a time, and only while a requester owns the resource.
- A tenure limit stops a requester from holding the resource indefinitely while others wait.
- Sits between the requesting agents and the Decoder instance. The decoder's one-hot output is the per-requester grant vector.

---
 rtl/decoder_rr_arbiter.sv | 75 +++++++
 tb/tb_decoder_rr_arbiter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/decoder_rr_arbiter.sv
// decoder_rr_arbiter: round-robin owner select with tenure limit, driving a decoder's sel/enable pair
module decoder_rr_arbiter #(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [WIDTH-1:0]         req_i,
  output logic [$clog2(WIDTH)-1:0] sel_o,
  output logic                     enable_o,
  output logic                     grant_new_o
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] CMAX = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  logic [0:0]       state_q, state_d;
  logic [SW-1:0]    sel_q, sel_d, last_q, last_d, win, k;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             gnew_q, gnew_d, found, rel, expd;
  logic [WIDTH-1:0] mask;
  // In GRANT the owner is excluded so expiry only finds other requesters; last_q equals sel_q there.
  always_comb begin
    mask  = req_i & ~((state_q == GRANT) ? (WIDTH'(1) << last_q) : '0);
    found = 1'b0;
    win   = last_q;
    k     = '0;
    for (int i = 1; i <= WIDTH; i++) begin
      k = SW'((int'(last_q) + i >= WIDTH) ? int'(last_q) + i - WIDTH : int'(last_q) + i);
      if (!found && mask[k]) begin
        found = 1'b1;
        win   = k;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnew_d  = 1'b0;
    rel     = (state_q == GRANT) && !req_i[sel_q];
    expd    = (state_q == GRANT) && (MAX_HOLD > 0) && (cnt_q == CMAX);
    if (found && ((state_q == IDLE) || rel || expd)) begin
      state_d = GRANT;
      sel_d   = win;
      last_d  = win;
      cnt_d   = '0;
      gnew_d  = 1'b1;
    end else if (rel) begin
      state_d = IDLE;
    end else if (state_q == GRANT) begin
      cnt_d = expd ? '0 : cnt_q + CW'(1);
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      last_q  <= SW'(WIDTH - 1);
      cnt_q   <= '0;
      gnew_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnew_q  <= gnew_d;
    end
  end
  assign sel_o       = sel_q;
  assign enable_o    = state_q;
  assign grant_new_o = gnew_q;
endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// tb_decoder_rr_arbiter: directed checks of arbitration order, tenure expiry, wrap and reset
module tb_decoder_rr_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] req;
  logic [3:0]  sel;
  logic        enable, grant_new;
  logic [15:0] dec;
  int checks = 0;
  int errors = 0;
  int order [5] = '{0, 5, 10, 15, 0};
  decoder_rr_arbiter #(.WIDTH(16), .MAX_HOLD(4)) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req),
    .sel_o(sel), .enable_o(enable), .grant_new_o(grant_new)
  );
  always #5 clk = ~clk;
  assign dec = enable ? (16'(1) << sel) : 16'h0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    tick();
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    req   = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_en", enable, 0);
      chk("rst_sel", sel, 0);
      chk("rst_gn", grant_new, 0);
    end
    reset = 1'b0;
    req   = 16'h0020;
    tick();
    chk("s1_sel", sel, 5);
    chk("s1_en", enable, 1);
    chk("s1_gn", grant_new, 1);
    chk("s1_dec", dec, 16'h0020);
    tick();
    chk("s1_gn_pulse", grant_new, 0);
    chk("s1_hold", enable, 1);
    req = '0;
    tick();
    chk("s1_idle_en", enable, 0);
    chk("s1_idle_sel", sel, 5);
    do_reset();
    req = 16'h8421;
    tick();
    chk("rr_first", sel, 0);
    chk("rr_first_gn", grant_new, 1);
    for (int k = 0; k < 4; k++) begin
      req = 16'h8421 & ~(16'(1) << order[k]);
      tick();
      chk("rr_sel", sel, order[k+1]);
      chk("rr_en", enable, 1);
      chk("rr_gn", grant_new, 1);
    end
    do_reset();
    req = 16'h0003;
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("ten_sel", sel, (k <= 4) ? 0 : (k <= 8) ? 1 : 0);
      chk("ten_gn", grant_new, (k == 1 || k == 5 || k == 9) ? 1 : 0);
      chk("ten_en", enable, 1);
    end
    do_reset();
    req = 16'h0100;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("sole_sel", sel, 8);
      chk("sole_en", enable, 1);
      chk("sole_gn", grant_new, (k == 1) ? 1 : 0);
    end
    do_reset();
    req = 16'h4000;
    tick();
    chk("wrap_14", sel, 14);
    req = 16'h0003;
    tick();
    chk("wrap_sel", sel, 0);
    chk("wrap_gn", grant_new, 1);
    chk("wrap_dec", dec, 16'h0001);
    req = '0;
    tick();
    chk("wrap_idle_en", enable, 0);
    chk("wrap_idle_sel", sel, 0);
    chk("wrap_idle_gn", grant_new, 0);
    do_reset();
    req = 16'hFFFF;
    begin
      int n = 0;
      while (!(enable && sel == 4'd9) && n < 100) begin
        tick();
        n++;
      end
      chk("mid_reach9", (enable && sel == 4'd9), 1);
    end
    reset = 1'b1;
    tick();
    chk("mid_rst_en", enable, 0);
    chk("mid_rst_sel", sel, 0);
    chk("mid_rst_gn", grant_new, 0);
    reset = 1'b0;
    tick();
    chk("mid_first_sel", sel, 0);
    chk("mid_first_en", enable, 1);
    chk("mid_first_gn", grant_new, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
